// File: rtl/sram_resp_pkg.sv
// Shared definitions for the SRAM responder.
// Contents: bus widths, the read-latency limit and its clamp helper, and the FSM state encoding.
// Optional feature macro used by the top: SRAM_RESP_PROTOCOL_CHECK_EN.
package sram_resp_pkg;

  localparam int unsigned DataW      = 16;
  localparam int unsigned BusAddrW   = 18;
  localparam int unsigned ReadLatMax = 7;
  localparam int unsigned CntW       = 3;

  typedef enum logic [2:0] {
    StIdle        = 3'd0,
    StReadWait    = 3'd1,
    StReadDrive   = 3'd2,
    StWriteActive = 3'd3,
    StWriteCommit = 3'd4
  } sram_state_e;

  // Out-of-range latencies saturate at the largest legal value.
  function automatic logic [CntW-1:0] clamp_lat(input int unsigned lat);
    return (lat > ReadLatMax) ? CntW'(ReadLatMax) : CntW'(lat);
  endfunction

endpackage

// File: rtl/sram_resp_storage.sv
// Word storage for the SRAM responder: one synchronous write port, one asynchronous read port.
// Ports:
//   clk_i   - write clock
//   we_i    - write enable
//   waddr_i - write address
//   wdata_i - write data (16 bits)
//   raddr_i - read address
//   rdata_o - read data, combinational from raddr_i
// Contents are never reset.
module sram_resp_storage
  import sram_resp_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DataW-1:0]  wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DataW-1:0]  rdata_o
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [DataW-1:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sram_responder.sv
// Asynchronous-SRAM-style slave: samples the external SRAM pins every edge and answers reads
// and writes from an internal word store.
// Ports:
//   clk       - clock, all state changes on rising edge
//   rst       - asynchronous active-low reset
//   addrBus   - 18-bit SRAM address (only the low ADDR_W bits are decoded)
//   dataBus   - 16-bit bidirectional data, driven only while busDrive is high
//   memEnable - active-low chip enable
//   memRead   - active-low output enable
//   memWrite  - active-low write enable
//   busDrive  - high exactly while dataBus is driven
//   protoErr  - sticky protocol-error flag, present only with SRAM_RESP_PROTOCOL_CHECK_EN
module sram_responder
  import sram_resp_pkg::*;
#(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned READ_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [BusAddrW-1:0] addrBus,
  inout  wire  [DataW-1:0]    dataBus,
  input  logic                memEnable,
  input  logic                memRead,
  input  logic                memWrite,
  output logic                busDrive
`ifdef SRAM_RESP_PROTOCOL_CHECK_EN
  ,
  output logic                protoErr
`endif
);

  localparam logic [CntW-1:0] LatLoad = clamp_lat(READ_LAT);

  // Input stage: the FSM looks only at these registered pin values.
  logic [BusAddrW-1:0] addr_q;
  logic [DataW-1:0]    data_q;
  logic                en_q, rd_q, wr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q <= '0;
      data_q <= '0;
      en_q   <= 1'b1;
      rd_q   <= 1'b1;
      wr_q   <= 1'b1;
    end else begin
      addr_q <= addrBus;
      data_q <= dataBus;
      en_q   <= memEnable;
      rd_q   <= memRead;
      wr_q   <= memWrite;
    end
  end

  logic [ADDR_W-1:0] samp_addr;
  logic              unused_addr_hi;
  assign samp_addr      = addr_q[ADDR_W-1:0];
  assign unused_addr_hi = ^addr_q[BusAddrW-1:ADDR_W];

  sram_state_e       state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DataW-1:0]  wr_data_q, wr_data_d;
  logic              mem_we;
  logic              go_idle;

  assign go_idle = en_q | (rd_q & wr_q);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rd_addr_d = rd_addr_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    mem_we    = 1'b0;
    unique case (state_q)
      StIdle, StReadWait, StReadDrive: begin
        if (go_idle) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (!wr_q) begin
          // Write wins over a simultaneous read.
          state_d   = StWriteActive;
          cnt_d     = '0;
          wr_addr_d = samp_addr;
          wr_data_d = data_q;
        end else if (state_q == StIdle || samp_addr != rd_addr_q) begin
          // New read or address change: restart the latency count.
          rd_addr_d = samp_addr;
          if (LatLoad == '0) begin
            state_d = StReadDrive;
            cnt_d   = '0;
          end else begin
            state_d = StReadWait;
            cnt_d   = LatLoad;
          end
        end else if (state_q == StReadWait) begin
          // The decrement to zero and the move to drive share one edge, so that a read
          // sampled at edge E is driven from edge E+1+READ_LAT.
          if (cnt_q <= CntW'(1)) begin
            state_d = StReadDrive;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CntW'(1);
          end
        end
      end
      StWriteActive: begin
        if (!en_q && !wr_q) begin
          wr_addr_d = samp_addr;
          wr_data_d = data_q;
        end else begin
          mem_we  = 1'b1;
          state_d = StWriteCommit;
        end
      end
      StWriteCommit: state_d = StIdle;
      default:       state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_addr_q <= rd_addr_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  logic [DataW-1:0] rd_data;

  sram_resp_storage #(
    .ADDR_W (ADDR_W)
  ) u_storage (
    .clk_i   (clk),
    .we_i    (mem_we),
    .waddr_i (wr_addr_q),
    .wdata_i (wr_data_q),
    .raddr_i (samp_addr),
    .rdata_o (rd_data)
  );

  // Gate on the latched address so a freshly sampled new address never drives stale timing.
  logic bus_drive;
  assign bus_drive = (state_q == StReadDrive) && (samp_addr == rd_addr_q);
  assign busDrive  = bus_drive;
  assign dataBus   = bus_drive ? rd_data : 'z;

`ifdef SRAM_RESP_PROTOCOL_CHECK_EN
  logic proto_err_q;
  logic proto_viol;

  assign proto_viol = (!en_q && !rd_q && !wr_q) ||
                      (state_q == StWriteActive && !en_q && !wr_q && samp_addr != wr_addr_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      proto_err_q <= 1'b0;
    end else if (proto_viol) begin
      proto_err_q <= 1'b1;
    end
  end

  assign protoErr = proto_err_q;
`endif

endmodule

// File: tb/tb_sram_responder.sv
// Self-checking bench for sram_responder with ADDR_W=10, READ_LAT=1.
// Reference model: a plain word array indexed by address modulo 2^ADDR_W plus the
// read-timing rule (sampled at edge E, driven from edge E+1+READ_LAT).
// Honours SRAM_RESP_PROTOCOL_CHECK_EN for the protoErr port.
module tb_sram_responder;

  localparam int unsigned AW  = 10;
  localparam int unsigned LAT = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic [17:0] addrBus;
  logic        memEnable, memRead, memWrite;
  logic        busDrive;
  wire  [15:0] dataBus;
  logic        tb_drv;
  logic [15:0] tb_data;
`ifdef SRAM_RESP_PROTOCOL_CHECK_EN
  logic        protoErr;
`endif

  assign dataBus = tb_drv ? tb_data : 'z;

  always #5 clk = ~clk;

  sram_responder #(
    .ADDR_W   (AW),
    .READ_LAT (LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .addrBus   (addrBus),
    .dataBus   (dataBus),
    .memEnable (memEnable),
    .memRead   (memRead),
    .memWrite  (memWrite),
    .busDrive  (busDrive)
`ifdef SRAM_RESP_PROTOCOL_CHECK_EN
    ,
    .protoErr  (protoErr)
`endif
  );

  int checks   = 0;
  int failures = 0;

  logic [15:0] model [1 << AW];
  int          written_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_pins();
    memEnable = 1'b1;
    memRead   = 1'b1;
    memWrite  = 1'b1;
    tb_drv    = 1'b0;
  endtask

  task automatic do_write(input logic [17:0] addr, input logic [15:0] data);
    memEnable = 1'b0;
    memWrite  = 1'b0;
    memRead   = 1'b1;
    addrBus   = addr;
    tb_data   = data;
    tb_drv    = 1'b1;
    tick();
    chk("write_nodrive", 32'(busDrive), 32'd0);
    idle_pins();
    repeat (3) tick();
    model[addr[AW-1:0]] = data;
    written_q.push_back(int'(addr[AW-1:0]));
  endtask

  // Read with the spec timing: not driven for edges E..E+READ_LAT, driven at E+1+READ_LAT.
  task automatic do_read(input logic [17:0] addr, input string tag);
    memEnable = 1'b0;
    memRead   = 1'b0;
    memWrite  = 1'b1;
    addrBus   = addr;
    tick();
    chk({tag, "_lat0"}, 32'(busDrive), 32'd0);
    repeat (LAT) begin
      tick();
      chk({tag, "_latwait"}, 32'(busDrive), 32'd0);
    end
    tick();
    chk({tag, "_drive"}, 32'(busDrive), 32'd1);
    chk({tag, "_data"}, 32'(dataBus), 32'(model[addr[AW-1:0]]));
    idle_pins();
    repeat (2) tick();
    chk({tag, "_release"}, 32'(busDrive), 32'd0);
    tick();
  endtask

  initial begin
    logic [15:0] v;
    bit          seen;

    rst     = 1'b0;
    addrBus = '0;
    tb_data = '0;
    idle_pins();
    repeat (2) tick();
    chk("reset_busdrive", 32'(busDrive), 32'd0);
`ifdef SRAM_RESP_PROTOCOL_CHECK_EN
    chk("reset_protoerr", 32'(protoErr), 32'd0);
`endif
    rst = 1'b1;
    tick();

    // Basic write then read.
    do_write(18'h00005, 16'h1234);
    do_read(18'h00005, "rd5");

    // Aliasing of upper address bits.
    do_write(18'h40001, 16'hAAAA);
    do_read(18'h00001, "alias1");

    // Address change while driving: released READ_LAT+1 edges, then new word.
    do_write(18'h00007, 16'(($urandom)));
    do_write(18'h00008, 16'(($urandom)));
    memEnable = 1'b0;
    memRead   = 1'b0;
    memWrite  = 1'b1;
    addrBus   = 18'h00007;
    repeat (LAT + 2) tick();
    chk("readdr_first_drive", 32'(busDrive), 32'd1);
    chk("readdr_first_data", 32'(dataBus), 32'(model[7]));
    addrBus = 18'h00008;
    for (int k = 0; k <= int'(LAT); k++) begin
      tick();
      chk("readdr_gap", 32'(busDrive), 32'd0);
    end
    tick();
    chk("readdr_second_drive", 32'(busDrive), 32'd1);
    chk("readdr_second_data", 32'(dataBus), 32'(model[8]));
    idle_pins();
    repeat (3) tick();

    // Read and write both low: write wins, bus never driven.
    memEnable = 1'b0;
    memRead   = 1'b0;
    memWrite  = 1'b0;
    addrBus   = 18'h00003;
    tb_data   = 16'hBEEF;
    tb_drv    = 1'b1;
    repeat (3) begin
      tick();
      chk("rdwr_nodrive", 32'(busDrive), 32'd0);
    end
    idle_pins();
    repeat (3) begin
      tick();
      chk("rdwr_nodrive_tail", 32'(busDrive), 32'd0);
    end
    model[3] = 16'hBEEF;
`ifdef SRAM_RESP_PROTOCOL_CHECK_EN
    chk("rdwr_protoerr", 32'(protoErr), 32'd1);
`endif
    do_read(18'h00003, "rdwr3");

    // Burst: only the last captured word is committed.
    do_write(18'h00020, 16'h5555);
    memEnable = 1'b0;
    memWrite  = 1'b0;
    memRead   = 1'b1;
    addrBus   = 18'h00020;
    tb_drv    = 1'b1;
    for (int d = 1; d <= 4; d++) begin
      tb_data = 16'(d);
      tick();
    end
    idle_pins();
    repeat (3) tick();
    model[32'h20] = 16'h0004;
    do_read(18'h00020, "burst");

    // Write immediately followed by read of the same address.
    v         = 16'(($urandom));
    memEnable = 1'b0;
    memWrite  = 1'b0;
    memRead   = 1'b1;
    addrBus   = 18'h00042;
    tb_data   = v;
    tb_drv    = 1'b1;
    tick();
    memWrite = 1'b1;
    memRead  = 1'b0;
    tb_drv   = 1'b0;
    model[32'h42] = v;
    seen = 1'b0;
    for (int c = 0; c < 12 && !seen; c++) begin
      tick();
      seen = busDrive;
    end
    chk("imm_read_drive", 32'(seen), 32'd1);
    chk("imm_read_data", 32'(dataBus), 32'(model[32'h42]));
    idle_pins();
    repeat (3) tick();

    // Reset while driving: bus released without a clock edge; storage survives.
    memEnable = 1'b0;
    memRead   = 1'b0;
    memWrite  = 1'b1;
    addrBus   = 18'h00005;
    repeat (LAT + 2) tick();
    chk("rstrd_drive", 32'(busDrive), 32'd1);
    rst = 1'b0;
    #1;
    chk("rstrd_async_release", 32'(busDrive), 32'd0);
    idle_pins();
    tick();
    rst = 1'b1;
    tick();
    do_read(18'h00005, "rstrd_keep");

    // Reset mid-write discards the uncommitted word.
    do_write(18'h00030, 16'hC0DE);
    memEnable = 1'b0;
    memWrite  = 1'b0;
    memRead   = 1'b1;
    addrBus   = 18'h00030;
    tb_data   = 16'hDEAD;
    tb_drv    = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    #1;
    idle_pins();
    tick();
    rst = 1'b1;
    tick();
    do_read(18'h00030, "rstwr_discard");

    // Random writes and aliased read-backs.
    repeat (16) begin
      logic [17:0] wa, ra;
      int          idx;
      wa = 18'($urandom_range(0, (1 << 18) - 1));
      do_write(wa, 16'(($urandom)));
      idx = int'($urandom_range(0, written_q.size() - 1));
      ra  = {8'($urandom), 10'(written_q[idx])};
      do_read(ra, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
